// File: rtl/serial_add_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and slice width.
package serial_add_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit slice adder; the only arithmetic resource of the block.
module nibble_adder
  import serial_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] total;

  // Widen to SLICE_W+1 bits so the carry falls out of the top bit.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
    s     = total[SLICE_W-1:0];
    cout  = total[SLICE_W];
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder: accepts an operand set, ripples one 4-bit slice per
// cycle through a single shared nibble_adder (LSB first), then holds the
// result until the consumer takes it.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SLICE_W*NIBBLES-1:0] a,
  input  logic [SLICE_W*NIBBLES-1:0] b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SLICE_W*NIBBLES-1:0] sum,
  output logic                   cout,
  output logic                   busy
);

  localparam int W     = SLICE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_t             state;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [IDX_W-1:0]   idx;
  logic               carry;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] add_s;
  logic               add_c;

  // Select the current slice of each captured operand for the shared adder.
  always_comb begin
    sl_a = a_q[SLICE_W*idx +: SLICE_W];
    sl_b = b_q[SLICE_W*idx +: SLICE_W];
  end

  nibble_adder u_add (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .s    (add_s),
    .cout (add_c)
  );

  // Control FSM; all handshake/status outputs are registered alongside state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is high here, so in_valid alone completes the handshake.
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            carry    <= cin;
            idx      <= '0;
            sum      <= '0;
            state    <= ADD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ADD: begin
          sum[SLICE_W*idx +: SLICE_W] <= add_s;
          carry                       <= add_c;
          if (idx == LAST) begin
            idx       <= '0;
            cout      <= add_c;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Result stays put until the consumer takes it.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random bench for serial_add_ctrl (NIBBLES=4).
module tb_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction: accept, N ADD edges, optional backpressure, release.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                        input logic [W-1:0] es, input logic ec, input int hold,
                        input bit interfere, input string tag);
    a = ta; b = tb2; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, "_rdy_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    if (interfere) begin
      a = ~ta; b = ta; cin = ~tc;
    end else begin
      in_valid = 1'b0;
    end
    for (int e = 1; e <= N; e++) begin
      chk({tag, "_rdy_add"}, 32'(in_ready), 32'd0);
      chk({tag, "_vld_add"}, 32'(out_valid), 32'd0);
      chk({tag, "_busy_add"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk({tag, "_vld_done"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_sum"}, 32'(sum), 32'(es));
      chk({tag, "_hold_cout"}, 32'(cout), 32'(ec));
      chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_rel_vld"}, 32'(out_valid), 32'd0);
    chk({tag, "_rel_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_rel_busy"}, 32'(busy), 32'd0);
    chk({tag, "_keep_sum"}, 32'(sum), 32'(es));
    chk({tag, "_keep_cout"}, 32'(cout), 32'(ec));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   exp_q[$];
    logic [W:0]   got;
    bit           fire_in, fire_out;
    int           done_cnt;
    int           cyc;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0, 1'b0, "zero");
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0, 1'b0, "carry8");
    run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 0, 1'b0, "ripple");
    run_op(16'h3A5C, 16'hD6B7, 1'b1, 16'h1114, 1'b1, 5, 1'b0, "hold");
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1, 1'b1, "ignore");

    // Reset in the middle of ADD after two slices.
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N + 2; k++) begin
      @(posedge clk); #1;
      chk("post_rst_vld", 32'(out_valid), 32'd0);
    end
    run_op(16'h8001, 16'h7FFF, 1'b0, 16'h0000, 1'b1, 0, 1'b0, "after_rst");

    // Random back-to-back traffic with random consumer backpressure.
    done_cnt = 0;
    cyc = 0;
    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
    while (done_cnt < 1000 && cyc < 40000) begin
      a = ra; b = rb; cin = rc; in_valid = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      got      = {cout, sum};
      @(posedge clk); #1;
      cyc++;
      if (fire_in) begin
        exp_q.push_back({1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
        chk("rnd_no_queue", 32'(exp_q.size()), 32'd1);
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      end
      if (fire_out) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious", 32'd1, 32'd0);
        end else begin
          chk("rnd_result", 32'(got), 32'(exp_q.pop_front()));
        end
        done_cnt++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rnd_count", 32'(done_cnt), 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
